fifo_flush_ctrl: RTL

//  Multi-channel FIFO drain controller. On a start pulse it empties a selected subset of NCH

---
 rtl/fifo_flush_pkg.sv | 21 ++
 rtl/ffc_prio_enc.sv | 20 ++
 rtl/fifo_flush_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_flush_pkg.sv
// fifo_flush_pkg: shared types for the FIFO drain controller.
// Holds the FSM state encoding and the channel index width helper.
package fifo_flush_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SEL   = ST_SEL,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ffc_prio_enc.sv
// ffc_prio_enc: lowest-set-bit encoder.
// Ports: req (N bits) -> idx (index of lowest set bit), valid (any set).
module ffc_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/fifo_flush_ctrl.sv
// fifo_flush_ctrl: drains a masked set of FIFOs one channel at a time.
// Ports: start/ch_mask/mode/flush_len/abort/fifo_empty in; rd_en/busy/done/aborted/rd_total out.
module fifo_flush_ctrl
  import fifo_flush_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             mode,
  input  logic [CNT_W-1:0] flush_len,
  input  logic             abort,
  input  logic [NCH-1:0]   fifo_empty,
  output logic [NCH-1:0]   rd_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W+3:0] rd_total
);

  localparam int IW = ch_idx_w(NCH);

  state_t           state;
  state_t           nxt;
  logic [NCH-1:0]   rem;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic [IW-1:0]    cur_ch;
  logic [CNT_W-1:0] cnt;

  logic [IW-1:0]    enc_idx;
  logic             enc_valid;
  logic [NCH-1:0]   cur_oh;
  logic             cur_empty;
  logic             rd_hit;
  logic             last_rd;
  logic             drain_exit;

  ffc_prio_enc #(
    .N  (NCH),
    .IW (IW)
  ) u_enc (
    .req   (rem),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign cur_oh    = NCH'(1) << cur_ch;
  assign cur_empty = fifo_empty[cur_ch];

  // Fixed mode reads blind; until-empty mode waits on the flag.
  assign rd_hit = (state == DRAIN)
                & (~mode_q | ~cur_empty)
                & ~abort;

  assign last_rd    = rd_hit & (cnt == len_q - CNT_W'(1));
  assign drain_exit = last_rd | (mode_q & cur_empty);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if ((ch_mask == '0) || (flush_len == '0))
            nxt = DONE;
          else
            nxt = SEL;
        end
      end
      SEL: begin
        if (abort)          nxt = DONE;
        else if (enc_valid) nxt = DRAIN;
        else                nxt = DONE;
      end
      DRAIN: begin
        if (abort)           nxt = DONE;
        else if (drain_exit) nxt = (rem != '0) ? SEL : DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = rd_hit ? cur_oh : '0;
    busy  = (state != IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      mode_q   <= 1'b0;
      len_q    <= '0;
      cur_ch   <= '0;
      cnt      <= '0;
      rd_total <= '0;
      aborted  <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem      <= ch_mask;
            mode_q   <= mode;
            len_q    <= flush_len;
            rd_total <= '0;
            aborted  <= 1'b0;
          end
        end
        SEL: begin
          if (enc_valid) begin
            cur_ch <= enc_idx;
            rem    <= rem & ~(NCH'(1) << enc_idx);
          end
          cnt <= '0;
          if (abort) aborted <= 1'b1;
        end
        DRAIN: begin
          if (rd_hit) begin
            cnt      <= cnt + CNT_W'(1);
            rd_total <= rd_total + (CNT_W+4)'(1);
          end
          if (abort) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
